pipe_memory_stage: RTL and testbench

Parametrised Y86-64 pipeline memory stage. It sits between the M and W pipeline registers and owns the word-addressed data memory. It adds configurable access latency with a stall request, status generation, and W-register stall/bubble control. Its forwarding taps (m_valM, M_valE, M_dstE, M_dstM) feed the decode-stage bypass.

---
 rtl/y86_pkg.sv | 30 +++
 rtl/pipe_memory_stage_if.sv | 35 +++
 rtl/data_mem.sv | 21 ++
 rtl/pipe_memory_stage.sv | 147 ++++++++++++++
 tb/tb_pipe_memory_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Y86-64 shared constants for the memory stage: instruction codes, status codes,
// register "none" marker, memory FSM states and op-class helpers.
package y86_pkg;

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {StIdle, StWait, StDone} mem_state_e;

  function automatic logic is_read_op(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IRET) || (icode == IPOPQ);
  endfunction

  function automatic logic is_write_op(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == ICALL) || (icode == IPUSHQ);
  endfunction

endpackage

// File: rtl/pipe_memory_stage_if.sv
// M-register inputs, W-register outputs and hazard handshake of the memory stage.
interface pipe_memory_stage_if #(
  parameter int unsigned DATA_W = 64
);
  logic [1:0]        M_stat;
  logic [3:0]        M_icode;
  logic              M_Cnd;
  logic [DATA_W-1:0] M_valE;
  logic [DATA_W-1:0] M_valA;
  logic [3:0]        M_dstE;
  logic [3:0]        M_dstM;
  logic              W_stall;
  logic              W_bubble;
  logic              mem_busy;
  logic [DATA_W-1:0] m_valM;
  logic [1:0]        m_stat;
  logic [1:0]        W_stat;
  logic [3:0]        W_icode;
  logic [DATA_W-1:0] W_valE;
  logic [DATA_W-1:0] W_valM;
  logic [3:0]        W_dstE;
  logic [3:0]        W_dstM;

  // Pipeline / hazard-unit side
  modport master (
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
    input  mem_busy, m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );

  // Memory stage side
  modport slave (
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
    output mem_busy, m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );
endinterface

// File: rtl/data_mem.sv
// Word-addressed data memory: write on the clock edge, combinational read.
module data_mem #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_DEPTH = 256,
  localparam int unsigned AddrW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AddrW-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Single write port, committed on the edge
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/pipe_memory_stage.sv
// Y86-64 memory stage between the M and W registers, with configurable access
// latency, stall request and W-register control.
// Optional MEM_PERF_CNT_EN adds saturating read/write/wait counters.
module pipe_memory_stage
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned LAT       = 1
) (
  input  logic              clk,
  input  logic              rst,
  pipe_memory_stage_if.slave bus
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]       perf_rd,
  output logic [31:0]       perf_wr,
  output logic [31:0]       perf_wait
`endif
);
  localparam int unsigned AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  CntInit = 4'(LAT - 1);

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] addr, rdata, valm_now;
  logic              is_rd, is_wr, dmem_error, access;
  logic              complete, w_load, we;

  data_mem #(
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_data_mem (
    .clk  (clk),
    .we   (we),
    .addr (addr[AW-1:0]),
    .wdata(bus.M_valA),
    .rdata(rdata)
  );

  // Address select, range check on the full address, stage status
  always_comb begin
    is_rd      = is_read_op(bus.M_icode);
    is_wr      = is_write_op(bus.M_icode);
    addr       = ((bus.M_icode == IRET) || (bus.M_icode == IPOPQ)) ? bus.M_valA : bus.M_valE;
    dmem_error = (is_rd || is_wr) && (addr >= DATA_W'(MEM_DEPTH));
    access     = (is_rd || is_wr) && !dmem_error && (bus.M_stat == SAOK);
    bus.m_stat = dmem_error ? SADR : bus.M_stat;
  end

  // Access FSM next state; w_load marks cycles where W may take new values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    w_load   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access && (LAT > 1)) begin
          cnt_d   = CntInit;
          state_d = StWait;
        end else begin
          complete = access;
          w_load   = 1'b1;
          if (access && bus.W_stall) state_d = StDone;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          complete = 1'b1;
          w_load   = 1'b1;
          state_d  = bus.W_stall ? StDone : StIdle;
        end
      end
      StDone: begin
        w_load = 1'b1;
        if (!bus.W_stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Read data seen by W: captured word in DONE, live array data on completion
  always_comb begin
    if (state_q == StDone)        valm_now = hold_q;
    else if (complete && is_rd)   valm_now = rdata;
    else                          valm_now = '0;
    hold_d = ((state_q == StWait) && !complete) ? hold_q : valm_now;
    we     = complete && is_wr && !rst;
  end

  assign bus.mem_busy = (state_q != StIdle);
  assign bus.m_valM   = hold_q;

  // FSM, hold register and W pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hold_q      <= '0;
      bus.W_stat  <= SAOK;
      bus.W_icode <= INOP;
      bus.W_valE  <= '0;
      bus.W_valM  <= '0;
      bus.W_dstE  <= RNONE;
      bus.W_dstM  <= RNONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      if (w_load && !bus.W_stall) begin
        if (bus.W_bubble) begin
          bus.W_stat  <= SAOK;
          bus.W_icode <= INOP;
          bus.W_valE  <= '0;
          bus.W_valM  <= '0;
          bus.W_dstE  <= RNONE;
          bus.W_dstM  <= RNONE;
        end else begin
          bus.W_stat  <= bus.m_stat;
          bus.W_icode <= bus.M_icode;
          bus.W_valE  <= bus.M_valE;
          bus.W_valM  <= valm_now;
          bus.W_dstE  <= bus.M_dstE;
          bus.W_dstM  <= bus.M_dstM;
        end
      end
    end
  end

`ifdef MEM_PERF_CNT_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd   <= '0;
      perf_wr   <= '0;
      perf_wait <= '0;
    end else begin
      if (complete && is_rd && (perf_rd != '1)) perf_rd <= perf_rd + 32'd1;
      if (complete && is_wr && (perf_wr != '1)) perf_wr <= perf_wr + 32'd1;
      if (bus.mem_busy && (perf_wait != '1))    perf_wait <= perf_wait + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_memory_stage.sv
// Bench for pipe_memory_stage: three instances with LAT=1,2,3 driven from per-instance
// stimulus arrays, directed scenarios plus a randomized run against a memory model.
module tb_pipe_memory_stage;
  import y86_pkg::*;

  localparam int unsigned DW = 64;
  localparam int          NI = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  d_stat   [NI];
  logic [3:0]  d_icode  [NI];
  logic        d_cnd    [NI];
  logic [63:0] d_vale   [NI];
  logic [63:0] d_vala   [NI];
  logic [3:0]  d_dste   [NI];
  logic [3:0]  d_dstm   [NI];
  logic        d_stall  [NI];
  logic        d_bubble [NI];

  logic        o_busy   [NI];
  logic [63:0] o_mvalm  [NI];
  logic [1:0]  o_mstat  [NI];
  logic [1:0]  o_wstat  [NI];
  logic [3:0]  o_wicode [NI];
  logic [63:0] o_wvale  [NI];
  logic [63:0] o_wvalm  [NI];
  logic [3:0]  o_wdste  [NI];
  logic [3:0]  o_wdstm  [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    pipe_memory_stage_if #(.DATA_W(DW)) bus ();
    assign bus.M_stat   = d_stat[k];
    assign bus.M_icode  = d_icode[k];
    assign bus.M_Cnd    = d_cnd[k];
    assign bus.M_valE   = d_vale[k];
    assign bus.M_valA   = d_vala[k];
    assign bus.M_dstE   = d_dste[k];
    assign bus.M_dstM   = d_dstm[k];
    assign bus.W_stall  = d_stall[k];
    assign bus.W_bubble = d_bubble[k];
    assign o_busy[k]    = bus.mem_busy;
    assign o_mvalm[k]   = bus.m_valM;
    assign o_mstat[k]   = bus.m_stat;
    assign o_wstat[k]   = bus.W_stat;
    assign o_wicode[k]  = bus.W_icode;
    assign o_wvale[k]   = bus.W_valE;
    assign o_wvalm[k]   = bus.W_valM;
    assign o_wdste[k]   = bus.W_dstE;
    assign o_wdstm[k]   = bus.W_dstM;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] p_rd, p_wr, p_wait;
`endif
    pipe_memory_stage #(
      .DATA_W   (DW),
      .MEM_DEPTH(256),
      .LAT      (k + 1)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef MEM_PERF_CNT_EN
      ,
      .perf_rd  (p_rd),
      .perf_wr  (p_wr),
      .perf_wait(p_wait)
`endif
    );
  end

  int checks = 0;
  int errors = 0;
  logic [63:0] mdl [NI][16];

  task automatic drive(input int k, input logic [1:0] st, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] va,
                       input logic [3:0] de, input logic [3:0] dm);
    d_stat[k] = st; d_icode[k] = ic; d_cnd[k] = 1'b0; d_vale[k] = ve; d_vala[k] = va;
    d_dste[k] = de; d_dstm[k] = dm; d_stall[k] = 1'b0; d_bubble[k] = 1'b0;
  endtask

  task automatic idle(input int k);
    drive(k, SAOK, INOP, 64'd0, 64'd0, RNONE, RNONE);
  endtask

  // Clock until the instance is not busy; nb = edges with busy seen high (capped)
  task automatic run(input int k, output int nb);
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!o_busy[k]) break;
      nb++;
    end
    idle(k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (o_busy[k] !== 1'b0) begin
        errors++; $display("FAIL reset_busy[%0d]: got %0b want 0", k, o_busy[k]);
      end
      checks++;
      if ({o_wstat[k], o_wicode[k], o_wdste[k], o_wdstm[k]} !== {SAOK, INOP, RNONE, RNONE}) begin
        errors++; $display("FAIL reset_wctl[%0d]: got %h/%h/%h/%h want 0/1/f/f", k, o_wstat[k],
                           o_wicode[k], o_wdste[k], o_wdstm[k]);
      end
      checks++;
      if ({o_wvale[k], o_wvalm[k], o_mvalm[k]} !== 192'd0) begin
        errors++; $display("FAIL reset_vals[%0d]: got %h %h %h want 0", k, o_wvale[k],
                           o_wvalm[k], o_mvalm[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_lat1_rw();
    int nb;
    drive(0, SAOK, IRMMOVQ, 64'd16, 64'hABCD, RNONE, RNONE);
    run(0, nb);
    checks++;
    if (nb !== 0) begin errors++; $display("FAIL lat1_wr_busy: got %0d want 0", nb); end
    drive(0, SAOK, IMRMOVQ, 64'd16, 64'd0, RNONE, 4'h3);
    run(0, nb);
    checks++;
    if (nb !== 0) begin errors++; $display("FAIL lat1_rd_busy: got %0d want 0", nb); end
    checks++;
    if (o_wvalm[0] !== 64'hABCD) begin
      errors++; $display("FAIL lat1_w_valm: got %h want abcd", o_wvalm[0]);
    end
    checks++;
    if (o_mvalm[0] !== 64'hABCD) begin
      errors++; $display("FAIL lat1_m_valm: got %h want abcd", o_mvalm[0]);
    end
    checks++;
    if ({o_wicode[0], o_wdstm[0]} !== {IMRMOVQ, 4'h3}) begin
      errors++; $display("FAIL lat1_w_icode_dstm: got %h %h want 5 3", o_wicode[0], o_wdstm[0]);
    end
  endtask

  task automatic test_lat3_pop();
    int nb;
    drive(2, SAOK, IRMMOVQ, 64'd8, 64'h55, RNONE, RNONE);
    run(2, nb);
    checks++;
    if (nb !== 2) begin errors++; $display("FAIL lat3_wr_busy: got %0d want 2", nb); end
    drive(2, SAOK, IPOPQ, 64'd16, 64'd8, 4'h4, 4'h0);
    @(posedge clk); #1;
    checks++;
    if ({o_busy[2], o_wicode[2]} !== {1'b1, IRMMOVQ}) begin
      errors++; $display("FAIL lat3_w_held: got busy=%0b icode=%h want 1 4", o_busy[2], o_wicode[2]);
    end
    run(2, nb);
    checks++;
    if (nb !== 1) begin errors++; $display("FAIL lat3_pop_busy_tail: got %0d want 1", nb); end
    checks++;
    if (o_wvalm[2] !== 64'h55) begin
      errors++; $display("FAIL lat3_pop_valm: got %h want 55", o_wvalm[2]);
    end
    checks++;
    if ({o_wicode[2], o_wvale[2]} !== {IPOPQ, 64'd16}) begin
      errors++; $display("FAIL lat3_pop_w: got %h %h want b 10", o_wicode[2], o_wvale[2]);
    end
  endtask

  task automatic test_adr();
    int nb;
    int ks [2] = '{0, 2};
    logic [63:0] pre;
    foreach (ks[i]) begin
      pre = 64'h1111_0000 + 64'(ks[i]);
      drive(ks[i], SAOK, IRMMOVQ, 64'd0, pre, RNONE, RNONE);
      run(ks[i], nb);
      drive(ks[i], SAOK, IMRMOVQ, 64'd256, 64'd0, RNONE, 4'h1);
      #1;
      checks++;
      if (o_mstat[ks[i]] !== SADR) begin
        errors++; $display("FAIL adr_m_stat[%0d]: got %0d want 2", ks[i], o_mstat[ks[i]]);
      end
      run(ks[i], nb);
      checks++;
      if ({nb[4:0], o_wstat[ks[i]], o_wvalm[ks[i]]} !== {5'd0, SADR, 64'd0}) begin
        errors++; $display("FAIL adr_rd[%0d]: got busy=%0d stat=%0d valm=%h want 0 2 0", ks[i],
                           nb, o_wstat[ks[i]], o_wvalm[ks[i]]);
      end
      drive(ks[i], SAOK, IRMMOVQ, 64'h8000_0000_0000_0000, 64'hDEAD, RNONE, RNONE);
      run(ks[i], nb);
      checks++;
      if ({nb[4:0], o_wstat[ks[i]]} !== {5'd0, SADR}) begin
        errors++; $display("FAIL adr_wr_hi[%0d]: got busy=%0d stat=%0d want 0 2", ks[i], nb,
                           o_wstat[ks[i]]);
      end
      drive(ks[i], SAOK, IRMMOVQ, 64'd256, 64'hBEEF, RNONE, RNONE);
      run(ks[i], nb);
      drive(ks[i], SAOK, IMRMOVQ, 64'd0, 64'd0, RNONE, 4'h1);
      run(ks[i], nb);
      checks++;
      if (o_wvalm[ks[i]] !== pre) begin
        errors++; $display("FAIL adr_mem_intact[%0d]: got %h want %h", ks[i], o_wvalm[ks[i]], pre);
      end
    end
  endtask

  task automatic test_stall_done();
    int nb;
    drive(1, SAOK, 4'h3, 64'd99, 64'd0, 4'h2, RNONE);
    run(1, nb);
    drive(1, SAOK, IPUSHQ, 64'd4, 64'd7, 4'h4, RNONE);
    @(posedge clk); #1;
    checks++;
    if (o_busy[1] !== 1'b1) begin errors++; $display("FAIL stall_wait_busy: got 0 want 1"); end
    d_stall[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      d_vala[1] = 64'd9;  // a second write would now be visible
      checks++;
      if ({o_busy[1], o_wicode[1]} !== {1'b1, 4'h3}) begin
        errors++; $display("FAIL stall_done_hold[%0d]: got busy=%0b icode=%h want 1 3", c,
                           o_busy[1], o_wicode[1]);
      end
    end
    d_stall[1] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({o_busy[1], o_wicode[1], o_wvale[1]} !== {1'b0, IPUSHQ, 64'd4}) begin
      errors++; $display("FAIL stall_release: got busy=%0b icode=%h vale=%h want 0 a 4",
                         o_busy[1], o_wicode[1], o_wvale[1]);
    end
    drive(1, SAOK, IMRMOVQ, 64'd4, 64'd0, RNONE, 4'h1);
    run(1, nb);
    checks++;
    if ({nb[4:0], o_wvalm[1]} !== {5'd1, 64'd7}) begin
      errors++; $display("FAIL stall_single_write: got busy=%0d valm=%h want 1 7", nb, o_wvalm[1]);
    end
  endtask

  task automatic test_ins_bubble();
    int nb;
    drive(0, SAOK, IRMMOVQ, 64'd20, 64'h77, RNONE, RNONE);
    run(0, nb);
    drive(0, SINS, IRMMOVQ, 64'd20, 64'h99, RNONE, RNONE);
    run(0, nb);
    checks++;
    if ({nb[4:0], o_wstat[0]} !== {5'd0, SINS}) begin
      errors++; $display("FAIL ins_w_stat: got busy=%0d stat=%0d want 0 3", nb, o_wstat[0]);
    end
    drive(0, SAOK, IMRMOVQ, 64'd20, 64'd0, RNONE, 4'h1);
    run(0, nb);
    checks++;
    if (o_wvalm[0] !== 64'h77) begin
      errors++; $display("FAIL ins_no_write: got %h want 77", o_wvalm[0]);
    end
    drive(0, SAOK, IMRMOVQ, 64'd20, 64'd0, 4'h2, 4'h3);
    d_bubble[0] = 1'b1;
    run(0, nb);
    checks++;
    if ({o_wstat[0], o_wicode[0], o_wdste[0], o_wdstm[0], o_wvalm[0]} !==
        {SAOK, INOP, RNONE, RNONE, 64'd0}) begin
      errors++; $display("FAIL bubble_w: got %h/%h/%h/%h/%h want 0/1/f/f/0", o_wstat[0],
                         o_wicode[0], o_wdste[0], o_wdstm[0], o_wvalm[0]);
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    drive(2, SAOK, IRMMOVQ, 64'd12, 64'h33, RNONE, RNONE);
    run(2, nb);
    drive(2, SAOK, IRMMOVQ, 64'd12, 64'h44, 4'h5, RNONE);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_busy[2] !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got 0 want 1"); end
    rst = 1'b1;
    @(posedge clk); #1;
    idle(2);
    checks++;
    if ({o_busy[2], o_wicode[2], o_wdste[2], o_wvale[2]} !== {1'b0, INOP, RNONE, 64'd0}) begin
      errors++; $display("FAIL rstmid_outputs: got busy=%0b icode=%h dste=%h vale=%h want 0 1 f 0",
                         o_busy[2], o_wicode[2], o_wdste[2], o_wvale[2]);
    end
    rst = 1'b0;
    drive(2, SAOK, IMRMOVQ, 64'd12, 64'd0, RNONE, 4'h1);
    run(2, nb);
    checks++;
    if (o_wvalm[2] !== 64'h33) begin
      errors++; $display("FAIL rstmid_no_write: got %h want 33", o_wvalm[2]);
    end
  endtask

  task automatic test_random();
    int nb, exp_nb;
    logic [3:0] ops [8] = '{INOP, 4'h6, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
    logic [3:0] ic, de, dm;
    logic [1:0] st, exp_st;
    logic [63:0] a, ve, va, exp_valm;
    logic rd, wr, err, acc;
    for (int k = 0; k < NI; k++) begin
      for (int w = 0; w < 16; w++) begin
        mdl[k][w] = {$urandom, $urandom};
        drive(k, SAOK, IRMMOVQ, 64'(w), mdl[k][w], RNONE, RNONE);
        run(k, nb);
      end
      for (int n = 0; n < 40; n++) begin
        ic = ops[$urandom_range(0, 7)];
        st = ($urandom_range(0, 9) == 0) ? SINS : (($urandom_range(0, 9) == 0) ? SHLT : SAOK);
        a  = ($urandom_range(0, 7) == 0) ? ({$urandom, $urandom} | 64'h100)
                                         : 64'($urandom_range(0, 15));
        ve = {$urandom, $urandom};
        va = {$urandom, $urandom};
        de = 4'($urandom_range(0, 15));
        dm = 4'($urandom_range(0, 15));
        if (ic == IRET || ic == IPOPQ) va = a; else ve = a;
        rd  = (ic == IMRMOVQ) || (ic == IRET) || (ic == IPOPQ);
        wr  = (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
        err = (rd || wr) && (a > 64'd255);
        acc = (rd || wr) && !err && (st == SAOK);
        exp_nb   = acc ? k : 0;
        exp_st   = err ? SADR : st;
        exp_valm = (acc && rd) ? mdl[k][a[3:0]] : 64'd0;
        if (acc && wr) mdl[k][a[3:0]] = va;
        drive(k, st, ic, ve, va, de, dm);
        run(k, nb);
        checks++;
        if (nb !== exp_nb) begin
          errors++; $display("FAIL rnd_busy[%0d.%0d]: got %0d want %0d", k, n, nb, exp_nb);
        end
        checks++;
        if ({o_wstat[k], o_wicode[k], o_wdste[k], o_wdstm[k]} !== {exp_st, ic, de, dm}) begin
          errors++; $display("FAIL rnd_wctl[%0d.%0d]: got %h/%h/%h/%h want %h/%h/%h/%h", k, n,
                             o_wstat[k], o_wicode[k], o_wdste[k], o_wdstm[k], exp_st, ic, de, dm);
        end
        checks++;
        if (o_wvale[k] !== ve) begin
          errors++; $display("FAIL rnd_vale[%0d.%0d]: got %h want %h", k, n, o_wvale[k], ve);
        end
        checks++;
        if (o_wvalm[k] !== exp_valm) begin
          errors++; $display("FAIL rnd_valm[%0d.%0d]: got %h want %h", k, n, o_wvalm[k], exp_valm);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NI; k++) idle(k);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_lat1_rw();
    test_lat3_pop();
    test_adr();
    test_stall_done();
    test_ins_bubble();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
